// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types for the ID/EX issue stage: the ALU Operation encoding
//   (fixed, must match the ALU), the ALUOp class from the main decoder,
//   and the payload word held in the stage's main and skid registers.
package alu_pkg;

   localparam int ISSUE_DATA_WIDTH     = 32;
   localparam int ISSUE_OPCODE_LENGTH  = 4;
   localparam int ISSUE_REG_ADDR_WIDTH = 5;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_XOR  = 4'b0001,
      ALU_OR   = 4'b0010,
      ALU_ADD  = 4'b0011,
      ALU_SUB  = 4'b0100,
      ALU_EQ   = 4'b0101,
      ALU_NE   = 4'b0110,
      ALU_LT   = 4'b0111,
      ALU_GE   = 4'b1000,
      ALU_SRL  = 4'b1001,
      ALU_SLL  = 4'b1010,
      ALU_SRA  = 4'b1011,
      ALU_TRUE = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_ARITH  = 2'b10,
      ALUOP_JUMP   = 2'b11
   } aluop_e;

   typedef struct packed {
      alu_op_e                         operation;
      logic [ISSUE_DATA_WIDTH-1:0]     srca;
      logic [ISSUE_DATA_WIDTH-1:0]     srcb;
      logic [ISSUE_REG_ADDR_WIDTH-1:0] rd;
      logic                            illegal;
   } issue_payload_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Bundle of the ID-side and EX-side handshakes of the issue stage plus
//   the flush request.
//   slave  : the issue stage view (consumes in_*, produces out_*).
//   master : the surrounding pipeline view (produces in_*, consumes out_*).
interface alu_issue_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int OPCODE_LENGTH  = 4,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic [1:0]                in_aluop;
   logic [2:0]                in_funct3;
   logic                      in_funct7_5;
   logic                      in_is_rtype;
   logic [DATA_WIDTH-1:0]     in_srca;
   logic [DATA_WIDTH-1:0]     in_srcb;
   logic [REG_ADDR_WIDTH-1:0] in_rd;
   logic                      out_valid;
   logic                      out_ready;
   logic [OPCODE_LENGTH-1:0]  out_operation;
   logic [DATA_WIDTH-1:0]     out_srca;
   logic [DATA_WIDTH-1:0]     out_srcb;
   logic [REG_ADDR_WIDTH-1:0] out_rd;
   logic                      out_illegal;

   modport slave (
      input  flush, in_valid, in_aluop, in_funct3, in_funct7_5, in_is_rtype,
             in_srca, in_srcb, in_rd, out_ready,
      output in_ready, out_valid, out_operation, out_srca, out_srcb, out_rd,
             out_illegal
   );

   modport master (
      output flush, in_valid, in_aluop, in_funct3, in_funct7_5, in_is_rtype,
             in_srca, in_srcb, in_rd, out_ready,
      input  in_ready, out_valid, out_operation, out_srca, out_srcb, out_rd,
             out_illegal
   );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode
//   Combinational ALU control decode.
//   aluop, funct3, funct7_5, is_rtype -> operation (4-bit ALU code), illegal.
//   Unsupported encodings decode to AND with illegal raised so the entry
//   can still flow down the pipe and be trapped later.
module alu_op_decode
   import alu_pkg::*;
(
   input  aluop_e     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output alu_op_e    operation,
   output logic       illegal
);

   always_comb begin
      operation = ALU_AND;
      illegal   = 1'b0;
      case (aluop)
         ALUOP_MEM:    operation = ALU_ADD;
         ALUOP_BRANCH: begin
            case (funct3)
               3'b000:  operation = ALU_EQ;
               3'b001:  operation = ALU_NE;
               3'b100:  operation = ALU_LT;
               3'b101:  operation = ALU_GE;
               default: illegal   = 1'b1;
            endcase
         end
         ALUOP_ARITH: begin
            case (funct3)
               // I-type has no SUB; bit 30 there is immediate data.
               3'b000:  operation = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b100:  operation = ALU_XOR;
               3'b110:  operation = ALU_OR;
               3'b111:  operation = ALU_AND;
               3'b001:  operation = ALU_SLL;
               3'b010:  operation = ALU_LT;
               3'b101:  operation = funct7_5 ? ALU_SRA : ALU_SRL;
               default: illegal   = 1'b1;   // SLTU has no ALU code
            endcase
         end
         ALUOP_JUMP:   operation = ALU_TRUE;
         default:      operation = ALU_AND;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   ID/EX issue stage: decodes the ALU control fields and registers the
//   operation with both operands behind a valid/ready handshake. A 2-entry
//   (main + skid) buffer keeps in_ready a pure register output, so EX
//   back-pressure never reaches ID combinationally.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : slave modport of alu_issue_stage_if (flush, in_*, out_*)
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   EMPTY  | nothing held, out_valid=0, in_ready=1
//   ONE    | main holds the oldest entry, out_valid=1, in_ready=1
//   TWO    | main oldest, skid next, out_valid=1, in_ready=0
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int OPCODE_LENGTH  = 4,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_issue_stage_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e         state;
   logic           in_ready_q;
   logic           out_valid_q;
   issue_payload_t main_q;
   issue_payload_t skid_q;
   issue_payload_t new_entry;
   alu_op_e        dec_operation;
   logic           dec_illegal;
   logic           accept;
   logic           consume;

   alu_op_decode u_decode (
      .aluop     (aluop_e'(bus.in_aluop)),
      .funct3    (bus.in_funct3),
      .funct7_5  (bus.in_funct7_5),
      .is_rtype  (bus.in_is_rtype),
      .operation (dec_operation),
      .illegal   (dec_illegal)
   );

   always_comb begin
      new_entry           = '0;
      new_entry.operation = dec_operation;
      new_entry.srca      = bus.in_srca;
      new_entry.srcb      = bus.in_srcb;
      new_entry.rd        = bus.in_rd;
      new_entry.illegal   = dec_illegal;
   end

   assign accept  = bus.in_valid & in_ready_q;
   assign consume = out_valid_q & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
      end else if (bus.flush) begin
         // A consume in this cycle has already happened on the wire; only
         // the held entries and any input presented now are discarded.
         state       <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_q      <= new_entry;
                  out_valid_q <= 1'b1;
                  state       <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && !consume) begin
                  skid_q     <= new_entry;
                  in_ready_q <= 1'b0;
                  state      <= ST_TWO;
               end else if (!accept && consume) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_EMPTY;
               end else if (accept && consume) begin
                  main_q <= new_entry;
               end
            end
            ST_TWO: begin
               // in_ready_q is low here, so no accept can coincide.
               if (consume) begin
                  main_q     <= skid_q;
                  in_ready_q <= 1'b1;
                  state      <= ST_ONE;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_operation = OPCODE_LENGTH'(main_q.operation);
   assign bus.out_srca      = DATA_WIDTH'(main_q.srca);
   assign bus.out_srcb      = DATA_WIDTH'(main_q.srcb);
   assign bus.out_rd        = REG_ADDR_WIDTH'(main_q.rd);
   assign bus.out_illegal   = main_q.illegal;

endmodule
